// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Shared constants for the integer datapath: default register-file geometry,
//   architectural register indices and the default stack-pointer reset value.
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned REGSIZE_DEF  = 64;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned REG_AW       = $clog2(NUM_REGS_DEF);

    // Architectural register indices
    localparam int unsigned X0 = 0;
    localparam int unsigned RA = 1;
    localparam int unsigned SP = 2;

    localparam logic [63:0] SP_RESET_DEF = 64'h0;

endpackage : core_pkg

// File: rtl/reg_file_rdport.sv
// ---------------------------------------------------------------------------
// reg_file_rdport
//   One combinational read port of the integer register file.
//   Ports:
//     addr     in   register index to read
//     regs     in   stored registers x1..x(NUM_REGS-1) (x0 is not stored)
//     wr_fire  in   a write is being committed on the coming clock edge
//     wr_addr  in   index of that write
//     wr_data  in   data of that write
//     data     out  read data; x0 always reads zero
// ---------------------------------------------------------------------------
module reg_file_rdport
    import core_pkg::*;
#(
    parameter int unsigned REGSIZE  = REGSIZE_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter bit          BYPASS   = 1'b0
) (
    input  logic [$clog2(NUM_REGS)-1:0] addr,
    input  logic [REGSIZE-1:0]          regs [1:NUM_REGS-1],
    input  logic                        wr_fire,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [REGSIZE-1:0]          wr_data,
    output logic [REGSIZE-1:0]          data
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    always_comb begin
        data = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (addr == AW'(i)) begin
                data = regs[i];
            end
        end
        // Forwarding never applies to x0, so the zero default above stands.
        if (BYPASS && wr_fire && (addr == wr_addr) && (addr != AW'(X0))) begin
            data = wr_data;
        end
    end

endmodule : reg_file_rdport

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Integer register file for the single-cycle RISC-V datapath.
//   NUM_REGS x REGSIZE state, x0 hardwired to zero, x2 (sp) resets to SP_RESET.
//   Ports:
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset
//     rs1_addr  in   read port 1 index      rs1_data  out  read port 1 data
//     rs2_addr  in   read port 2 index      rs2_data  out  read port 2 data
//     we        in   write enable           rd_addr   in   write index
//     rd_data   in   write data
//     dbg_addr  in   debug read index       dbg_data  out  debug read data
// ---------------------------------------------------------------------------
module reg_file
    import core_pkg::*;
#(
    parameter int unsigned          REGSIZE  = REGSIZE_DEF,
    parameter int unsigned          NUM_REGS = NUM_REGS_DEF,
    parameter logic [REGSIZE-1:0]   SP_RESET = REGSIZE'(SP_RESET_DEF),
    parameter bit                   BYPASS   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
    output logic [REGSIZE-1:0]          rs1_data,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
    output logic [REGSIZE-1:0]          rs2_data,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
    input  logic [REGSIZE-1:0]          rd_data,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
    output logic [REGSIZE-1:0]          dbg_data
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [REGSIZE-1:0] regs_q [1:NUM_REGS-1];
    logic [REGSIZE-1:0] regs_d [1:NUM_REGS-1];

    // Write arm: cleared by reset, set by the first clock edge after release.
    // Blocks the write on the edge that ends the reset cycle, so a write
    // presented alongside reset deassertion is never taken, regardless of how
    // rst_n and clk happen to line up.
    logic wr_arm_q;
    logic wr_arm_d;
    logic wr_fire;

    always_comb begin
        wr_arm_d = 1'b1;
        wr_fire  = we && wr_arm_q;
    end

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_fire && (rd_addr == AW'(i))) begin
                regs_d[i] = rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_arm_q <= 1'b0;
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP) ? SP_RESET : '0;
            end
        end else begin
            wr_arm_q <= wr_arm_d;
            regs_q   <= regs_d;
        end
    end

    reg_file_rdport #(
        .REGSIZE  (REGSIZE),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
    ) u_rs1 (
        .addr     (rs1_addr),
        .regs     (regs_q),
        .wr_fire  (wr_fire),
        .wr_addr  (rd_addr),
        .wr_data  (rd_data),
        .data     (rs1_data)
    );

    reg_file_rdport #(
        .REGSIZE  (REGSIZE),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
    ) u_rs2 (
        .addr     (rs2_addr),
        .regs     (regs_q),
        .wr_fire  (wr_fire),
        .wr_addr  (rd_addr),
        .wr_data  (rd_data),
        .data     (rs2_data)
    );

    reg_file_rdport #(
        .REGSIZE  (REGSIZE),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
    ) u_dbg (
        .addr     (dbg_addr),
        .regs     (regs_q),
        .wr_fire  (wr_fire),
        .wr_addr  (rd_addr),
        .wr_data  (rd_data),
        .data     (dbg_data)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed bench for reg_file. Two instances share all inputs:
//   dut_a with BYPASS=0 and dut_b with BYPASS=1, both with a non-zero SP_RESET.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam logic [63:0] SPV = 64'h8000_0000_0000_1000;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
    logic        we;
    logic [63:0] rd_data;
    logic [63:0] a_rs1, a_rs2, a_dbg;
    logic [63:0] b_rs1, b_rs2, b_dbg;

    int checks = 0;
    int errors = 0;

    reg_file #(
        .REGSIZE  (64),
        .NUM_REGS (32),
        .SP_RESET (SPV),
        .BYPASS   (1'b0)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs1_data (a_rs1),
        .rs2_addr (rs2_addr),
        .rs2_data (a_rs2),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (a_dbg)
    );

    reg_file #(
        .REGSIZE  (64),
        .NUM_REGS (32),
        .SP_RESET (SPV),
        .BYPASS   (1'b1)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs1_data (b_rs1),
        .rs2_addr (rs2_addr),
        .rs2_data (b_rs2),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (b_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] fill_val(input int unsigned i);
        return (i == 0) ? 64'h0 : 64'(i) * 64'h0101;
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);  // arming edge: no write is taken here
    endtask

    task automatic test_reset();
        rs1_addr = 5'd2; rs2_addr = 5'd0; dbg_addr = 5'd5;
        #1;
        checks++; if (a_rs1 !== SPV) begin errors++; $display("FAIL reset_sp_a got %h exp %h", a_rs1, SPV); end
        checks++; if (b_rs1 !== SPV) begin errors++; $display("FAIL reset_sp_b got %h exp %h", b_rs1, SPV); end
        checks++; if (a_rs2 !== 64'h0) begin errors++; $display("FAIL reset_x0 got %h exp %h", a_rs2, 64'h0); end
        checks++; if (a_dbg !== 64'h0) begin errors++; $display("FAIL reset_x5 got %h exp %h", a_dbg, 64'h0); end
        // Writes during reset are ignored, also on the bypass path
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd5; rd_data = 64'hFFFF_0000_FFFF_0000;
        #1;
        checks++; if (b_dbg !== 64'h0) begin errors++; $display("FAIL reset_bypass_gated got %h exp %h", b_dbg, 64'h0); end
        @(posedge clk); #1;
        checks++; if (a_dbg !== 64'h0) begin errors++; $display("FAIL reset_write_ignored got %h exp %h", a_dbg, 64'h0); end
        we = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd5; rd_data = 64'h1234;
        @(negedge clk);
        we = 1'b0; dbg_addr = 5'd5;
        #1;
        checks++; if (a_dbg !== 64'h1234) begin errors++; $display("FAIL async_pre got %h exp %h", a_dbg, 64'h1234); end
        #2;
        rst_n = 1'b0;  // mid-cycle, no clock edge
        #1;
        checks++; if (a_dbg !== 64'h0) begin errors++; $display("FAIL async_x5_a got %h exp %h", a_dbg, 64'h0); end
        checks++; if (b_dbg !== 64'h0) begin errors++; $display("FAIL async_x5_b got %h exp %h", b_dbg, 64'h0); end
        dbg_addr = 5'd2;
        #1;
        checks++; if (a_dbg !== SPV) begin errors++; $display("FAIL async_sp got %h exp %h", a_dbg, SPV); end
        release_reset();
    endtask

    task automatic test_write_latency();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd7; rd_data = 64'hDEAD_BEEF_0000_0001; rs1_addr = 5'd7;
        #1;
        checks++; if (a_rs1 !== 64'h0) begin errors++; $display("FAIL lat_old_a got %h exp %h", a_rs1, 64'h0); end
        checks++; if (b_rs1 !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL lat_fwd_b got %h exp %h", b_rs1, 64'hDEAD_BEEF_0000_0001); end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        checks++; if (a_rs1 !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL lat_new_a got %h exp %h", a_rs1, 64'hDEAD_BEEF_0000_0001); end
        checks++; if (b_rs1 !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL lat_new_b got %h exp %h", b_rs1, 64'hDEAD_BEEF_0000_0001); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        checks++; if ({a_rs1, a_rs2, a_dbg} !== 192'h0) begin errors++; $display("FAIL x0_before_a got %h %h %h exp 0", a_rs1, a_rs2, a_dbg); end
        we = 1'b1; rd_addr = 5'd0; rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if ({a_rs1, a_rs2, a_dbg} !== 192'h0) begin errors++; $display("FAIL x0_during_a got %h %h %h exp 0", a_rs1, a_rs2, a_dbg); end
        checks++; if ({b_rs1, b_rs2, b_dbg} !== 192'h0) begin errors++; $display("FAIL x0_during_b got %h %h %h exp 0", b_rs1, b_rs2, b_dbg); end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        checks++; if ({a_rs1, a_rs2, a_dbg} !== 192'h0) begin errors++; $display("FAIL x0_after_a got %h %h %h exp 0", a_rs1, a_rs2, a_dbg); end
        checks++; if ({b_rs1, b_rs2, b_dbg} !== 192'h0) begin errors++; $display("FAIL x0_after_b got %h %h %h exp 0", b_rs1, b_rs2, b_dbg); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd3; rd_data = 64'h42; rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        checks++; if (b_rs1 !== 64'h42) begin errors++; $display("FAIL byp_rs1_b got %h exp %h", b_rs1, 64'h42); end
        checks++; if (b_rs2 !== 64'h42) begin errors++; $display("FAIL byp_rs2_b got %h exp %h", b_rs2, 64'h42); end
        checks++; if (a_rs1 !== 64'h0) begin errors++; $display("FAIL byp_old_a got %h exp %h", a_rs1, 64'h0); end
        @(posedge clk); #1;
        we = 1'b0; rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        checks++; if (b_rs1 !== 64'h42) begin errors++; $display("FAIL byp_hold_rs1_b got %h exp %h", b_rs1, 64'h42); end
        checks++; if (b_rs2 !== 64'h42) begin errors++; $display("FAIL byp_hold_rs2_b got %h exp %h", b_rs2, 64'h42); end
        checks++; if (a_rs1 !== 64'h42) begin errors++; $display("FAIL byp_hold_a got %h exp %h", a_rs1, 64'h42); end
        // we=0 across an edge leaves state unchanged
        @(posedge clk); #1;
        checks++; if (a_rs2 !== 64'h42) begin errors++; $display("FAIL we_low_a got %h exp %h", a_rs2, 64'h42); end
    endtask

    task automatic test_fill_sweep();
        logic [63:0] e_dbg, e_rs1, e_rs2;
        for (int unsigned i = 1; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; rd_addr = 5'(i); rd_data = fill_val(i);
        end
        @(negedge clk);
        we = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            #1;
            e_dbg = fill_val(i);
            e_rs1 = fill_val(int'(rs1_addr));
            e_rs2 = fill_val(int'(rs2_addr));
            checks++; if (a_dbg !== e_dbg) begin errors++; $display("FAIL sweep_dbg_a[%0d] got %h exp %h", i, a_dbg, e_dbg); end
            checks++; if (b_dbg !== e_dbg) begin errors++; $display("FAIL sweep_dbg_b[%0d] got %h exp %h", i, b_dbg, e_dbg); end
            checks++; if (a_rs1 !== e_rs1) begin errors++; $display("FAIL sweep_rs1_a[%0d] got %h exp %h", rs1_addr, a_rs1, e_rs1); end
            checks++; if (b_rs2 !== e_rs2) begin errors++; $display("FAIL sweep_rs2_b[%0d] got %h exp %h", rs2_addr, b_rs2, e_rs2); end
        end
    endtask

    task automatic test_reset_release_write();
        @(negedge clk);
        dbg_addr = 5'd9;
        rst_n = 1'b0;
        #1;
        checks++; if (a_dbg !== 64'h0) begin errors++; $display("FAIL rrw_reset_x9 got %h exp %h", a_dbg, 64'h0); end
        @(negedge clk);
        rst_n = 1'b1; we = 1'b1; rd_addr = 5'd9; rd_data = 64'h77;
        @(posedge clk); #1;
        checks++; if (a_dbg !== 64'h0) begin errors++; $display("FAIL rrw_first_edge got %h exp %h", a_dbg, 64'h0); end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        checks++; if (a_dbg !== 64'h77) begin errors++; $display("FAIL rrw_second_edge_a got %h exp %h", a_dbg, 64'h77); end
        checks++; if (b_dbg !== 64'h77) begin errors++; $display("FAIL rrw_second_edge_b got %h exp %h", b_dbg, 64'h77); end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; dbg_addr = '0; rd_data = '0;
        repeat (2) @(negedge clk);
        test_reset();
        release_reset();
        test_async_reset();
        test_write_latency();
        test_x0();
        test_bypass();
        test_fill_sweep();
        test_reset_release_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
